// File: rtl/hex_ascii_pkg.sv
// Shared constants and types for the ASCII-hex token parser.
package hex_ascii_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [1:0] {StIdle, StAccum, StOut, StSkip} parser_state_e;

    typedef enum logic [1:0] {ClsDigit, ClsTerm, ClsBad} char_class_e;

endpackage

// File: rtl/ascii_hex_digit_decode.sv
// Classifies one ASCII character as hex digit, terminator or bad character.
// Define HEX_PARSER_LOWERCASE_EN to accept 'a'-'f' as digits.
module ascii_hex_digit_decode
    import hex_ascii_pkg::*;
(
    input  logic [7:0]  char_i,
    output char_class_e cls_o,
    output logic [3:0]  nib_o
);

    always_comb begin
        cls_o = ClsBad;
        nib_o = 4'd0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            cls_o = ClsDigit;
            nib_o = char_i[3:0];
        end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
            cls_o = ClsDigit;
            nib_o = char_i[3:0] + 4'd9;
`ifdef HEX_PARSER_LOWERCASE_EN
        end else if (char_i >= 8'h61 && char_i <= 8'h66) begin
            cls_o = ClsDigit;
            nib_o = char_i[3:0] + 4'd9;
`else
`endif
        end else if (char_i == ASCII_CR || char_i == ASCII_LF || char_i == ASCII_SP) begin
            cls_o = ClsTerm;
        end
    end

endmodule

// File: rtl/hex_ascii_to_word.sv
// Parses a stream of ASCII hex characters into words emitted on a valid/ready port.
// Lowercase digit support is controlled by HEX_PARSER_LOWERCASE_EN (see decoder).
module hex_ascii_to_word
    import hex_ascii_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_DIGITS = WIDTH / 4,
    localparam int unsigned CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_digits,
    output logic             err_badchar,
    output logic             err_ovf
);

    localparam logic [CW-1:0] MaxCnt = CW'(MAX_DIGITS);

    parser_state_e    state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_digits_q, out_digits_d;
    logic             err_badchar_q, err_badchar_d;
    logic             err_ovf_q, err_ovf_d;

    char_class_e cls;
    logic [3:0]  nib;
    logic        accept;

    ascii_hex_digit_decode u_decode (
        .char_i (in_char),
        .cls_o  (cls),
        .nib_o  (nib)
    );

    assign out_valid   = (state_q == StOut);
    assign in_ready    = (state_q != StOut);
    assign accept      = in_valid & in_ready;
    assign out_data    = out_data_q;
    assign out_digits  = out_digits_q;
    assign err_badchar = err_badchar_q;
    assign err_ovf     = err_ovf_q;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        count_d       = count_q;
        out_data_d    = out_data_q;
        out_digits_d  = out_digits_q;
        err_badchar_d = 1'b0;
        err_ovf_d     = 1'b0;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    unique case (cls)
                        ClsDigit: begin
                            if (count_q == MaxCnt) begin
                                err_ovf_d = 1'b1;
                                state_d   = StSkip;
                                acc_d     = '0;
                                count_d   = '0;
                            end else begin
                                acc_d   = {acc_q[WIDTH-5:0], nib};
                                count_d = count_q + CW'(1);
                                state_d = StAccum;
                            end
                        end
                        ClsTerm: begin
                            // Empty tokens (repeated CR/LF/space) are swallowed.
                            if (count_q != '0) begin
                                state_d      = StOut;
                                out_data_d   = acc_q;
                                out_digits_d = count_q;
                            end
                        end
                        default: begin
                            err_badchar_d = 1'b1;
                            state_d       = StSkip;
                            acc_d         = '0;
                            count_d       = '0;
                        end
                    endcase
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: begin
                if (accept && cls == ClsTerm) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            count_q       <= '0;
            out_data_q    <= '0;
            out_digits_q  <= '0;
            err_badchar_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            out_data_q    <= out_data_d;
            out_digits_q  <= out_digits_d;
            err_badchar_q <= err_badchar_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

endmodule
